// File: rtl/heu_multipass_ctrl_if.sv
// rtl/heu_multipass_ctrl_if.sv - control/handshake bundle for the multipass heuristic sequencer
`timescale 1ns/1ps

interface heu_multipass_ctrl_if #(
    parameter int N_PASSES = 1
);
    localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    logic              prev_out_ready;
    logic              next_in_ready;
    logic              sum_ready;
    logic              bypass;
    logic              flush;
    logic              in_ready;
    logic              write_in;
    logic              zero_cnts;
    logic              rotate_in;
    logic              enable_calc;
    logic              sum_go;
    logic              pass_done;
    logic              shift_out;
    logic              out_ready;
    logic              busy;
    logic [PASS_W-1:0] pass_idx;

    modport master (
        input  prev_out_ready, next_in_ready, sum_ready, bypass, flush,
        output in_ready, write_in, zero_cnts, rotate_in, enable_calc,
               sum_go, pass_done, shift_out, out_ready, busy, pass_idx
    );

    modport slave (
        output prev_out_ready, next_in_ready, sum_ready, bypass, flush,
        input  in_ready, write_in, zero_cnts, rotate_in, enable_calc,
               sum_go, pass_done, shift_out, out_ready, busy, pass_idx
    );
endinterface

// File: rtl/heu_multipass_ctrl.sv
// rtl/heu_multipass_ctrl.sv - multi-pass calc/sum/move sequencer with bypass and sync flush
`timescale 1ns/1ps

module heu_multipass_ctrl #(
    parameter int N_ELEM   = 80,
    parameter int N_PASSES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    heu_multipass_ctrl_if.master bus
);
    localparam int CNT_W  = $clog2(N_ELEM + 1);
    localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_ELEM);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(N_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SUM,
        S_MOVE,
        S_HOLD
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PASS_W-1:0] pass;
    logic              bypass_q;

    logic cnt_done;
    logic pass_final;

    assign cnt_done   = (cnt == CNT_LAST);
    assign pass_final = (pass == PASS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pass     <= '0;
            bypass_q <= 1'b0;
        end else if (bus.flush) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pass     <= '0;
            bypass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.prev_out_ready) begin
                        cnt      <= '0;
                        pass     <= '0;
                        bypass_q <= bus.bypass;
                        state    <= bus.bypass ? S_MOVE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (!cnt_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= S_SUM;
                    end
                end
                S_SUM: begin
                    if (bus.sum_ready) begin
                        cnt <= '0;
                        if (!pass_final) begin
                            pass  <= pass + 1'b1;
                            state <= S_CALC;
                        end else begin
                            state <= S_MOVE;
                        end
                    end
                end
                S_MOVE: begin
                    if (!cnt_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= bus.next_in_ready ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.next_in_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from state/cnt; accept and out_ready must react in the same cycle.
    always_comb begin
        bus.in_ready    = (state == S_IDLE);
        bus.busy        = (state != S_IDLE);
        bus.pass_idx    = pass;
        bus.write_in    = 1'b0;
        bus.zero_cnts   = 1'b0;
        bus.rotate_in   = 1'b0;
        bus.enable_calc = 1'b0;
        bus.sum_go      = 1'b0;
        bus.pass_done   = 1'b0;
        bus.shift_out   = 1'b0;
        bus.out_ready   = 1'b0;
        if (!bus.flush) begin
            case (state)
                S_IDLE: begin
                    bus.write_in  = bus.prev_out_ready;
                    bus.zero_cnts = bus.prev_out_ready;
                end
                S_CALC: begin
                    bus.rotate_in   = !cnt_done && !bypass_q;
                    bus.enable_calc = !cnt_done && !bypass_q;
                    bus.sum_go      = cnt_done && !bypass_q;
                end
                S_SUM: begin
                    bus.pass_done = bus.sum_ready && !pass_final && !bypass_q;
                end
                S_MOVE: begin
                    bus.rotate_in = !cnt_done;
                    bus.shift_out = !cnt_done;
                    bus.out_ready = cnt_done;
                end
                S_HOLD: begin
                    bus.out_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_heu_multipass_ctrl.sv
// tb/tb_heu_multipass_ctrl.sv - scoreboard bench for heu_multipass_ctrl (N_ELEM=4, 1 and 3 passes)
`timescale 1ns/1ps

module tb_heu_multipass_ctrl;
    localparam int NE = 4;

    // {in_ready, busy, write_in, zero_cnts, rotate_in, enable_calc, sum_go, pass_done, shift_out, out_ready}
    localparam logic [9:0] V_RST = 10'b10_0000_0000;
    localparam logic [9:0] V_ACC = 10'b10_1100_0000;
    localparam logic [9:0] V_CAL = 10'b01_0011_0000;
    localparam logic [9:0] V_SGO = 10'b01_0000_1000;
    localparam logic [9:0] V_PDN = 10'b01_0000_0100;
    localparam logic [9:0] V_SHF = 10'b01_0010_0010;
    localparam logic [9:0] V_ORY = 10'b01_0000_0001;
    localparam logic [9:0] TRIG  = 10'b00_1111_1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    heu_multipass_ctrl_if #(.N_PASSES(1)) ia ();
    heu_multipass_ctrl_if #(.N_PASSES(3)) ib ();

    heu_multipass_ctrl #(.N_ELEM(NE), .N_PASSES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia.master)
    );

    heu_multipass_ctrl #(.N_ELEM(NE), .N_PASSES(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib.master)
    );

    wire [9:0] va = {ia.in_ready, ia.busy, ia.write_in, ia.zero_cnts, ia.rotate_in,
                     ia.enable_calc, ia.sum_go, ia.pass_done, ia.shift_out, ia.out_ready};
    wire [9:0] vb = {ib.in_ready, ib.busy, ib.write_in, ib.zero_cnts, ib.rotate_in,
                     ib.enable_calc, ib.sum_go, ib.pass_done, ib.shift_out, ib.out_ready};

    typedef struct {
        logic [9:0] vec;
        int         pidx;
        int         gap;
    } ev_t;

    ev_t  q_a[$];
    ev_t  q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_a = 0;
    int   last_b = 0;
    logic blk_b = 1'b0;

    task automatic push(input bit b, input logic [9:0] v, input int p, input int g, input int n);
        for (int i = 0; i < n; i++) begin
            ev_t e;
            e.vec  = v;
            e.pidx = p;
            e.gap  = (i == 0) ? g : 1;
            if (b) q_b.push_back(e);
            else   q_a.push_back(e);
        end
    endtask

    task automatic push_full_a(input int g0);
        push(0, V_ACC, 0, g0, 1);
        push(0, V_CAL, 0, 1, NE);
        push(0, V_SGO, 0, 1, 1);
        push(0, V_SHF, 0, 2, NE);
        push(0, V_ORY, 0, 1, 1);
    endtask

    task automatic push_full_b(input int acc_pidx);
        push(1, V_ACC, acc_pidx, -1, 1);
        push(1, V_CAL, 0, 1, NE);
        push(1, V_SGO, 0, 1, 1);
        push(1, V_PDN, 0, 1, 1);
        push(1, V_CAL, 1, 1, NE);
        push(1, V_SGO, 1, 1, 1);
        push(1, V_PDN, 1, 1, 1);
        push(1, V_CAL, 2, 1, NE);
        push(1, V_SGO, 2, 1, 1);
        push(1, V_SHF, 2, 2, NE);
        push(1, V_ORY, 2, 1, 1);
    endtask

    task automatic compare_ev(input string nm, input ev_t e, input logic [9:0] v, input int p, input int g);
        checks++;
        if (v !== e.vec || p != e.pidx || (e.gap >= 0 && g != e.gap)) begin
            errors++;
            $display("FAIL %s: got vec=%b pass_idx=%0d gap=%0d, expected vec=%b pass_idx=%0d gap=%0d",
                     nm, v, p, g, e.vec, e.pidx, e.gap);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitors: every cycle with any strobe up pops one expected event.
    initial forever begin
        @(negedge clk);
        if (rst_n && (va & TRIG) != 10'd0) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_a: got vec=%b, expected no event", va);
            end else begin
                compare_ev("event_a", q_a.pop_front(), va, int'(ia.pass_idx), cyc - last_a);
            end
            last_a = cyc;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && (vb & TRIG) != 10'd0) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b: got vec=%b, expected no event", vb);
            end else begin
                compare_ev("event_b", q_b.pop_front(), vb, int'(ib.pass_idx), cyc - last_b);
            end
            last_b = cyc;
        end
    end

    // Summation unit model: sum_ready one cycle after sum_go.
    initial begin
        logic sa;
        logic sb;
        ia.sum_ready = 1'b0;
        ib.sum_ready = 1'b0;
        forever begin
            @(negedge clk);
            sa = ia.sum_go;
            sb = ib.sum_go;
            @(posedge clk);
            #1;
            ia.sum_ready = sa;
            ib.sum_ready = sb && !blk_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ia.prev_out_ready = 1'b0; ia.next_in_ready = 1'b1; ia.bypass = 1'b0; ia.flush = 1'b0;
        ib.prev_out_ready = 1'b0; ib.next_in_ready = 1'b1; ib.bypass = 1'b0; ib.flush = 1'b0;
        repeat (2) tick();
        chk("reset_vec_a", int'(va), int'(V_RST));
        chk("reset_vec_b", int'(vb), int'(V_RST));
        chk("reset_pass_b", int'(ib.pass_idx), 0);
        rst_n = 1'b1;
        tick();

        // back-to-back sets, prev_out_ready held high
        ia.prev_out_ready = 1'b1;
        push_full_a(-1);
        push_full_a(1);
        repeat (13) tick();
        ia.prev_out_ready = 1'b0;
        repeat (14) tick();
        chk("drain_b2b", q_a.size(), 0);

        // three passes
        ib.prev_out_ready = 1'b1;
        push_full_b(0);
        tick();
        ib.prev_out_ready = 1'b0;
        repeat (26) tick();
        chk("drain_multipass", q_b.size(), 0);

        // bypass
        ia.prev_out_ready = 1'b1;
        ia.bypass = 1'b1;
        push(0, V_ACC, 0, -1, 1);
        push(0, V_SHF, 0, 1, NE);
        push(0, V_ORY, 0, 1, 1);
        tick();
        ia.prev_out_ready = 1'b0;
        ia.bypass = 1'b0;
        repeat (8) tick();
        chk("drain_bypass", q_a.size(), 0);

        // HOLD for 10 cycles, prev_out_ready high throughout
        ia.prev_out_ready = 1'b1;
        ia.next_in_ready = 1'b0;
        push(0, V_ACC, 0, -1, 1);
        push(0, V_CAL, 0, 1, NE);
        push(0, V_SGO, 0, 1, 1);
        push(0, V_SHF, 0, 2, NE);
        push(0, V_ORY, 0, 1, 11);
        repeat (21) tick();
        ia.next_in_ready = 1'b1;
        tick();
        ia.prev_out_ready = 1'b0;
        @(negedge clk);
        chk("hold_exit_in_ready", int'(ia.in_ready), 1);
        chk("hold_exit_out_ready", int'(ia.out_ready), 0);
        repeat (3) tick();
        chk("drain_hold", q_a.size(), 0);

        // flush in CALC at cnt=2
        ia.prev_out_ready = 1'b1;
        push(0, V_ACC, 0, -1, 1);
        push(0, V_CAL, 0, 1, 2);
        tick();
        ia.prev_out_ready = 1'b0;
        repeat (2) tick();
        ia.flush = 1'b1;
        tick();
        ia.flush = 1'b0;
        @(negedge clk);
        chk("flush_calc_in_ready", int'(ia.in_ready), 1);
        chk("flush_calc_busy", int'(ia.busy), 0);
        chk("drain_flush_calc", q_a.size(), 0);
        tick();
        ia.prev_out_ready = 1'b1;
        push_full_a(-1);
        tick();
        ia.prev_out_ready = 1'b0;
        repeat (14) tick();
        chk("drain_after_flush_a", q_a.size(), 0);

        // flush in the second pass's SUM
        ib.prev_out_ready = 1'b1;
        push(1, V_ACC, 2, -1, 1);
        push(1, V_CAL, 0, 1, NE);
        push(1, V_SGO, 0, 1, 1);
        push(1, V_PDN, 0, 1, 1);
        push(1, V_CAL, 1, 1, NE);
        push(1, V_SGO, 1, 1, 1);
        tick();
        ib.prev_out_ready = 1'b0;
        repeat (7) tick();
        blk_b = 1'b1;
        repeat (5) tick();
        ib.flush = 1'b1;
        tick();
        ib.flush = 1'b0;
        @(negedge clk);
        chk("flush_sum_pass_idx", int'(ib.pass_idx), 0);
        chk("flush_sum_in_ready", int'(ib.in_ready), 1);
        chk("drain_flush_sum", q_b.size(), 0);
        tick();
        blk_b = 1'b0;
        ib.prev_out_ready = 1'b1;
        push_full_b(0);
        tick();
        ib.prev_out_ready = 1'b0;
        repeat (26) tick();
        chk("drain_after_flush_b", q_b.size(), 0);

        // async reset during MOVE cnt=3
        ia.prev_out_ready = 1'b1;
        push(0, V_ACC, 0, -1, 1);
        push(0, V_CAL, 0, 1, NE);
        push(0, V_SGO, 0, 1, 1);
        push(0, V_SHF, 0, 2, 3);
        tick();
        ia.prev_out_ready = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_vec_a", int'(va), int'(V_RST));
        chk("drain_pre_reset", q_a.size(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        chk("no_out_after_reset", q_a.size(), 0);
        ia.prev_out_ready = 1'b1;
        push_full_a(-1);
        tick();
        ia.prev_out_ready = 1'b0;
        repeat (14) tick();
        chk("drain_final_a", q_a.size(), 0);
        chk("drain_final_b", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
